// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared types and constants for the CPU/loader RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int DEFAULT_ADDR_W = 9;
    localparam int DEFAULT_DATA_W = 32;

    // Grant encoding, also the value exposed on last_gnt
    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LD  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    function automatic logic other_port(input logic gnt);
        return (gnt == GNT_CPU) ? GNT_LD : GNT_CPU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Combinational two-way round-robin pick between CPU and loader.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic i_req_cpu,
    input  logic i_req_ld,
    input  logic i_last_gnt,
    output logic o_valid,
    output logic o_winner
);

    always_comb begin
        o_valid  = i_req_cpu | i_req_ld;
        o_winner = GNT_CPU;
        // On a tie the port that did not win last time goes first
        if (i_req_cpu && i_req_ld) begin
            o_winner = other_port(i_last_gnt);
        end else if (i_req_ld) begin
            o_winner = GNT_LD;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates CPU and loader/debug ports onto one single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              clr,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic              busy,
    output logic              last_gnt
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_any_req;
    logic              w_winner;
    logic              w_grant;
    logic              w_read_done;

    rr_arb2 u_rr_arb2 (
        .i_req_cpu  (c_req),
        .i_req_ld   (d_req),
        .i_last_gnt (r_last_gnt),
        .o_valid    (w_any_req),
        .o_winner   (w_winner)
    );

    assign w_grant     = (r_state == IDLE) && w_any_req;
    assign w_read_done = (r_state == RESP) && !r_we;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= IDLE;
            r_last_gnt <= GNT_LD;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_c_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last_gnt <= w_winner;
                r_we       <= (w_winner == GNT_LD) ? d_we    : c_we;
                r_addr     <= (w_winner == GNT_LD) ? d_addr  : c_addr;
                r_wdata    <= (w_winner == GNT_LD) ? d_wdata : c_wdata;
            end
            if (w_read_done) begin
                if (r_last_gnt == GNT_LD) begin
                    r_d_rdata <= ram_rdata;
                end else begin
                    r_c_rdata <= ram_rdata;
                end
            end
        end
    end

    // RAM read data is forwarded during RESP so it is visible alongside ack
    always_comb begin
        busy      = (r_state != IDLE);
        last_gnt  = r_last_gnt;
        ram_read  = (r_state == ACCESS) && !r_we;
        ram_write = (r_state == ACCESS) &&  r_we;
        ram_addr  = busy ? r_addr  : '0;
        ram_wdata = busy ? r_wdata : '0;
        c_ack     = (r_state == RESP) && (r_last_gnt == GNT_CPU);
        d_ack     = (r_state == RESP) && (r_last_gnt == GNT_LD);
        c_rdata   = (w_read_done && (r_last_gnt == GNT_CPU)) ? ram_rdata : r_c_rdata;
        d_rdata   = (w_read_done && (r_last_gnt == GNT_LD))  ? ram_rdata : r_d_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clr;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_ack, d_ack;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          ram_read, ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          busy, last_gnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .clr(clr),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .last_gnt(last_gnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: read data appears the cycle after ram_read
    logic [DW-1:0] tb_mem [512];
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 512; i++) tb_mem[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (ram_write) tb_mem[ram_addr] <= ram_wdata;
            if (ram_read)  ram_rdata <= tb_mem[ram_addr];
        end
    end

    a_excl: assert property (@(posedge clk) disable iff (clr) !(ram_read && ram_write))
        else $error("assert: ram_read and ram_write high together");
    a_two_ack: assert property (@(posedge clk) disable iff (clr) !(c_ack && d_ack))
        else $error("assert: both acks high");
    a_c_pulse: assert property (@(posedge clk) disable iff (clr) c_ack |=> !c_ack)
        else $error("assert: c_ack longer than one cycle");
    a_d_pulse: assert property (@(posedge clk) disable iff (clr) d_ack |=> !d_ack)
        else $error("assert: d_ack longer than one cycle");

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
        bit            drop;
    } txn_t;

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        int            cyc;
    } exp_t;

    txn_t scr [2][$];
    exp_t strobe_q[$];
    exp_t ack_q[$];
    bit   busy_exp [int];
    int   ack_cyc_log[$];
    bit   ack_port_log[$];

    logic [DW-1:0] ref_mem [512];
    bit            m_last = 1'b1;
    int            m_free = 0;
    bit            act [2];
    bit            gnt [2];
    int            g_cyc [2];
    int            a_cyc [2];
    txn_t          cur [2];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // One clock: requesters drive their ports, then the reference model decides
    task automatic tick(input bit rst);
        bit   rq [2];
        bit   w;
        txn_t t;
        exp_t e;
        @(posedge clk);
        #1;
        clr = rst;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0;
            if (act[p] && gnt[p] && cyc > a_cyc[p]) act[p] = 1'b0;
            if (!act[p] && scr[p].size() > 0) begin
                t = scr[p][0];
                if (t.gap > 0) begin
                    t.gap--;
                    scr[p][0] = t;
                end else begin
                    cur[p] = scr[p].pop_front();
                    act[p] = 1'b1;
                    gnt[p] = 1'b0;
                end
            end
            if (act[p]) rq[p] = !(gnt[p] && cur[p].drop && cyc > g_cyc[p]);
        end
        c_req   = rq[0];
        c_we    = act[0] ? cur[0].we    : 1'($urandom);
        c_addr  = act[0] ? cur[0].addr  : AW'($urandom);
        c_wdata = act[0] ? cur[0].wdata : $urandom;
        d_req   = rq[1];
        d_we    = act[1] ? cur[1].we    : 1'($urandom);
        d_addr  = act[1] ? cur[1].addr  : AW'($urandom);
        d_wdata = act[1] ? cur[1].wdata : $urandom;

        if (rst) begin
            m_last = 1'b1;
            m_free = cyc + 1;
            for (int i = 0; i < 512; i++) ref_mem[i] = '0;
            while (strobe_q.size() > 0 && strobe_q[$].cyc > cyc) void'(strobe_q.pop_back());
            while (ack_q.size() > 0 && ack_q[$].cyc > cyc) void'(ack_q.pop_back());
            busy_exp.delete(cyc + 1);
            busy_exp.delete(cyc + 2);
            act[0] = 1'b0;
            act[1] = 1'b0;
        end else if (cyc >= m_free && (rq[0] || rq[1])) begin
            w      = (rq[0] && rq[1]) ? !m_last : rq[1];
            m_last = w;
            m_free = cyc + 3;
            e.port  = w;
            e.we    = cur[w].we;
            e.addr  = cur[w].addr;
            e.wd    = cur[w].wdata;
            e.rd    = ref_mem[cur[w].addr];
            if (cur[w].we) ref_mem[cur[w].addr] = cur[w].wdata;
            e.cyc = cyc + 1;
            strobe_q.push_back(e);
            e.cyc = cyc + 2;
            ack_q.push_back(e);
            busy_exp[cyc + 1] = 1'b1;
            busy_exp[cyc + 2] = 1'b1;
            gnt[w]   = 1'b1;
            g_cyc[w] = cyc;
            a_cyc[w] = cyc + 2;
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((act[0] || act[1] || scr[0].size() > 0 || scr[1].size() > 0) && n < limit) begin
            tick(1'b0);
            n++;
        end
        chk("drain_timeout", 64'(n >= limit), 64'd0);
        repeat (3) tick(1'b0);
    endtask

    task automatic push(input int p, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int gap, input bit drop);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.gap = gap; t.drop = drop;
        scr[p].push_back(t);
    endtask

    // Monitor: compares DUT outputs against the queued expectations each cycle
    logic [DW-1:0] exp_rd [2];
    bit            exp_last = 1'b1;
    always @(negedge clk) begin : mon
        exp_t e;
        bit   b;
        if (cyc >= 1) begin
            b = busy_exp.exists(cyc);
            chk("busy", 64'(busy), 64'(b));
            if (!b) begin
                chk("ram_addr_idle", 64'(ram_addr), 64'd0);
                chk("ram_wdata_idle", 64'(ram_wdata), 64'd0);
            end
            if (strobe_q.size() > 0 && strobe_q[0].cyc == cyc) begin
                e = strobe_q.pop_front();
                exp_last = e.port;
                chk("ram_read", 64'(ram_read), 64'(!e.we));
                chk("ram_write", 64'(ram_write), 64'(e.we));
                chk("ram_addr", 64'(ram_addr), 64'(e.addr));
                chk("ram_wdata", 64'(ram_wdata), 64'(e.wd));
            end else begin
                chk("no_strobe", 64'({ram_read, ram_write}), 64'd0);
            end
            chk("last_gnt", 64'(last_gnt), 64'(exp_last));
            if (c_ack || d_ack) begin
                ack_cyc_log.push_back(cyc);
                ack_port_log.push_back(d_ack);
            end
            if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
                e = ack_q.pop_front();
                if (!e.we) exp_rd[e.port] = e.rd;
                chk("ack_port", 64'({c_ack, d_ack}), e.port ? 64'd1 : 64'd2);
            end else begin
                chk("no_ack", 64'({c_ack, d_ack}), 64'd0);
            end
            chk("c_rdata", 64'(c_rdata), 64'(exp_rd[0]));
            chk("d_rdata", 64'(d_rdata), 64'(exp_rd[1]));
            if (clr) begin
                exp_rd[0] = '0;
                exp_rd[1] = '0;
                exp_last  = 1'b1;
            end
            busy_exp.delete(cyc);
        end
    end

    initial begin
        int t0;
        int n;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        clr = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        repeat (3) tick(1'b1);

        // CPU write then read back
        push(0, 1'b1, 9'h010, 32'hDEADBEEF, 0, 1'b0);
        push(0, 1'b0, 9'h010, 32'h0, 0, 1'b0);
        drain(50);
        chk("dir_cpu_readback", 64'(c_rdata), 64'h0000_0000_DEAD_BEEF);

        // Round-robin from reset with both ports loaded
        repeat (3) tick(1'b1);
        ack_cyc_log.delete();
        ack_port_log.delete();
        push(0, 1'b0, 9'h001, 32'h0, 0, 1'b0);
        push(0, 1'b0, 9'h002, 32'h0, 0, 1'b0);
        push(1, 1'b0, 9'h003, 32'h0, 0, 1'b0);
        push(1, 1'b0, 9'h004, 32'h0, 0, 1'b0);
        t0 = cyc + 1;
        drain(50);
        chk("rr_ack_count", 64'(ack_cyc_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_cyc_log.size()) begin
                chk("rr_ack_cycle", 64'(ack_cyc_log[i] - t0), 64'(2 + 3 * i));
                chk("rr_ack_port", 64'(ack_port_log[i]), 64'(i % 2));
            end
        end

        // Loader write at top address, CPU read back
        push(1, 1'b1, 9'h1FF, 32'h12345678, 0, 1'b0);
        push(0, 1'b0, 9'h1FF, 32'h0, 3, 1'b0);
        drain(50);
        chk("dir_loader_to_cpu", 64'(c_rdata), 64'h0000_0000_1234_5678);

        // Reset during the ACCESS cycle of a CPU read
        gnt[0] = 1'b0;
        push(0, 1'b0, 9'h1FF, 32'h0, 0, 1'b0);
        n = 0;
        do begin
            tick(1'b0);
            n++;
        end while (!gnt[0] && n < 20);
        chk("abort_grant_seen", 64'(gnt[0]), 64'd1);
        tick(1'b1);
        tick(1'b0);
        chk("abort_no_ack", 64'(c_ack), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_strobes", 64'({ram_read, ram_write}), 64'd0);
        chk("abort_c_rdata", 64'(c_rdata), 64'd0);
        chk("abort_last_gnt", 64'(last_gnt), 64'd1);
        drain(20);

        // CPU drops req during ACCESS of a read
        push(0, 1'b1, 9'h055, 32'hA5A50F0F, 0, 1'b0);
        push(0, 1'b0, 9'h055, 32'h0, 0, 1'b1);
        drain(50);
        chk("dir_drop_read", 64'(c_rdata), 64'h0000_0000_A5A5_0F0F);

        // Randomized traffic on both ports
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 150; i++) begin
                push(p, 1'($urandom),
                     ($urandom_range(0, 3) == 0) ? AW'(9'h1F8 + $urandom_range(0, 7))
                                                 : AW'($urandom_range(0, 15)),
                     $urandom, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
            end
        end
        drain(3000);

        chk("strobe_q_empty", 64'(strobe_q.size()), 64'd0);
        chk("ack_q_empty", 64'(ack_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set the RAM word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 clr  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 c_req, c_we  in  1 each  SHALL be the CPU (MAR/MDR side) request level and write-enable.
REQ-006 c_addr  in  ADDR_W, c_wdata  in  DATA_W  SHALL be the CPU address and write data.
REQ-007 c_ack  out  1, c_rdata  out  DATA_W  SHALL be the CPU completion pulse and read data.
REQ-008 d_req, d_we, d_addr, d_wdata, d_ack, d_rdata SHALL be the loader/debug port, with the same widths and meanings as the c_* ports.
REQ-009 ram_read, ram_write  out  1  SHALL be the RAM strobes.
REQ-010 ram_addr  out  ADDR_W, ram_wdata  out  DATA_W  SHALL drive the RAM address and write data.
REQ-011 ram_rdata  in  DATA_W  SHALL be the RAM read data, valid the cycle after ram_read.
REQ-012 busy  out  1, last_gnt  out  1 (0=CPU, 1=loader)  SHALL expose arbiter status.

Function
REQ-013 States SHALL be IDLE, ACCESS and RESP only.
REQ-014 In IDLE with any req high, the arbiter SHALL latch the winner's we, addr and wdata, update last_gnt, and enter ACCESS on the next edge.
REQ-015 With both req high in IDLE, the winner SHALL be the port not equal to last_gnt (round-robin); with a single req, that port SHALL win.
REQ-016 In ACCESS, ram_read=!we or ram_write=we SHALL be asserted for exactly one cycle with the latched addr/wdata; then RESP.
REQ-017 In RESP, the winner's ack SHALL pulse high for exactly one cycle.
REQ-018 For a read, the winner's rdata SHALL load ram_rdata at the RESP edge.
REQ-019 FSM SHALL return to IDLE after RESP.
REQ-020 Latency SHALL be fixed: req seen in IDLE at cycle N -> RAM strobe at cycle N+1 -> ack at cycle N+2; the next grant is possible at N+3.
REQ-021 Requesters SHALL hold req and fields until ack and drop req on the edge after ack; req still high in IDLE SHALL be treated as a new request.
REQ-022 A req dropped after latching SHALL NOT cancel the transaction; ack SHALL still pulse.
REQ-023 The losing port's req SHALL be ignored until the next IDLE and never lost or acked.
REQ-024 c_rdata/d_rdata SHALL hold their value until that port's next read completes; writes SHALL NOT change them.
REQ-025 ram_read and ram_write SHALL never be high simultaneously, and SHALL be low outside ACCESS.
REQ-026 busy SHALL be high in ACCESS and RESP, low in IDLE.
REQ-027 ram_addr/ram_wdata SHALL show the latched values in ACCESS and RESP, and zero in IDLE.

Reset
REQ-028 With clr high at an edge: state SHALL go to IDLE, last_gnt=1 (CPU wins the first tie), and acks, strobes, busy, rdata, latched fields and ram_addr/ram_wdata SHALL all be 0.
REQ-029 clr mid-transaction SHALL abort it with no ack and no RAM strobe in the following cycle.
REQ-030 clr SHALL take precedence over every req.

Structure
REQ-031 A shared package SHALL hold the state enum, the ADDR_W/DATA_W defaults and the grant encoding (GNT_CPU=0, GNT_LD=1).
REQ-032 A sub-module rr_arb2 SHALL hold the 2-way round-robin pick (inputs: two reqs, last_gnt; output: winner), and SHALL be purely combinational.

Verification
REQ-033 CPU write addr 0x010 data 0xDEADBEEF, then read 0x010 -> ram_write at N+1, c_ack at N+2; read gives c_rdata=0xDEADBEEF at its ack; d_ack stays 0.
REQ-034 c_req and d_req both high from reset, each held until its ack -> grant order CPU, loader, CPU, loader; acks at cycles 2, 5, 8, 11.
REQ-035 Loader write 0x1FF data 0x12345678, then CPU read 0x1FF -> c_rdata=0x12345678; ram_addr=0x1FF during both ACCESS cycles.
REQ-036 clr asserted in the ACCESS cycle of a CPU read -> no c_ack, ram strobes 0, busy 0 next cycle; c_rdata=0 and last_gnt=1.
REQ-037 CPU read with c_req dropped in the ACCESS cycle -> c_ack still pulses once and c_rdata is updated.
REQ-038 Assertion throughout all runs: never ram_read&&ram_write, ack never for both ports in one cycle, and acks are always one-cycle pulses.
